bcd_display_sequencer: RTL and testbench
========================================

// Module: bcd_display_sequencer
// PURPOSE
//  Time-shared binary-to-decimal converter feeding the LCD status panel. It replaces
//  per-value combinational %10 / %100 logic with one iterative double-dabble unit.
//  On each T6 rising edge it snapshots ACC, B and the operand. It converts the three
//  values in turn, ACC -> B -> operand, and latches the digit registers that drive lcd_top.
// PARAMETERS
//  ASCII_ZERO   8'h30  offset added to operand BCD digits
//  ASCII_BLANK  8'h20  code driven on operand digits when blanked
//  AUTO_TRIG    1      1: T6 rising edge and start both trigger; 0: start only
// PORTS
//  CLK          in   1  system clock, 50 MHz
//  CLRn         in   1  synchronous active-low reset
//  T6           in   1  CPU beat T6 (CLK-synchronous level); rising edge = trigger
//  start        in   1  one-cycle manual trigger
//  acc_in       in   8  Dout_ACC value
//  b_in         in   8  Dout_B value
//  operand_in   in   8  instruction operand
//  operand_blank in  1  1 = operand not meaningful (no operand / JMP-less ops); blank it
//  A_bai/A_shi/A_ge  out 4 each  ACC hundreds/tens/ones, BCD
//  B_bai/B_shi/B_ge  out 4 each  B hundreds/tens/ones, BCD
//  operand_shi  out  8  operand tens, ASCII
//  operand_ge   out  8  operand ones, ASCII
//  busy         out  1  conversion sequence in progress
//  done         out  1  one-cycle pulse: all three channels updated
// BEHAVIOUR
//  Reset (CLRn=0 at a CLK edge):
//   - All BCD outputs go to 0; operand_shi/ge go to ASCII_BLANK.
//   - busy=0, done=0, pending=0, T6 edge register=0, FSM goes to IDLE.
//   - Reset mid-sequence aborts it; a partial result is never written.
//  Trigger: trig = start | (AUTO_TRIG & T6 & ~T6_q). T6_q is registered every cycle.
//  FSM states: IDLE, LOAD, SHIFT, STORE. Channel counter ch ranges 0..2.
//  - IDLE + trig at edge k: snapshot acc_in, b_in, operand_in, operand_blank; set ch=0;
//    go to LOAD. busy=1 from edge k.
//  - LOAD (1 cycle): bin <= snapshot[ch]; bcd[11:0] <= 0; cnt <= 0; go to SHIFT.
//  - SHIFT (8 cycles), each cycle:
//    - add 3 to every bcd nibble that is >= 5;
//    - then shift {bcd,bin} left by 1; cnt++;
//    - after cnt=7, go to STORE.
//  - STORE (1 cycle), writes channel ch only:
//    - ch=0: A_* <= bcd nibbles. ch=1: B_* <= bcd nibbles.
//    - ch=2: operand_shi = blank ? ASCII_BLANK : bcd[7:4]+ASCII_ZERO;
//      operand_ge = blank ? ASCII_BLANK : bcd[3:0]+ASCII_ZERO.
//      The hundreds digit of the operand is dropped.
//    - If ch<2: ch++, go to LOAD.
//    - If ch=2: done=1 for this one cycle, busy=0, go to IDLE.
//  Latency: 10 cycles per channel.
//   - A_* updates at edge k+10, B_* at k+20, operand_* at k+30; done is high in the
//     cycle after edge k+30.
//   - Outputs not being stored hold their values, so the display never shows a
//     half-converted digit.
//  Trigger while busy: sets pending (1 deep; further triggers collapse into it).
//   - At STORE of ch=2 with pending=1: clear pending, take a fresh snapshot, go to
//     LOAD, ch=0.
//   - In this case done still pulses and busy stays 1.
//  Trigger in the same cycle as the final STORE counts as pending.
//  Snapshot isolation: input changes after edge k do not affect the running sequence.
//  Range: 0..255. Hundreds digit is 0..2; tens and ones are 0..9.
// TESTING
//  - Reset: CLRn=0 then release -> all BCD=0, operand_*=8'h20, busy=0, done=0.
//  - ACC=8'd255, B=8'd0, operand=8'd37, blank=0, T6 rise -> at k+10 A=2/5/5; at k+20
//    B=0/0/0; at k+30 operand_shi=8'h33, operand_ge=8'h37; done pulses for 1 cycle.
//  - operand=8'd99, blank=1 -> operand_shi=operand_ge=8'h20; ACC=8'd100 -> A=1/0/0.
//  - Change acc_in from 12 to 200 at k+3 -> A reads 0/1/2 at k+10; a T6 rise at k+5
//    -> second sequence starts at k+30; A reads 2/0/0 at k+40; done pulses twice.
//  - CLRn=0 at k+15 -> outputs at reset values, busy=0, no done pulse; a later T6
//    rise converts normally.
//  - AUTO_TRIG=0: T6 toggling -> no activity; start pulse -> full 30-cycle sequence.

Source files
------------

// File: rtl/bcd_display_sequencer.sv
// Time-shared double-dabble converter for the LCD status panel.
// A trigger snapshots ACC, B and the operand. The three values are then converted
// in turn (ACC -> B -> operand), 10 cycles per channel.
// Ports:
//   CLK, CLRn           clock, synchronous active-low reset
//   T6, start           trigger sources (T6 rising edge if AUTO_TRIG, start pulse)
//   acc_in, b_in        8-bit register values to display as BCD
//   operand_in          8-bit operand, displayed as two ASCII digits
//   operand_blank       1 = show ASCII_BLANK on the operand digits
//   A_*/B_*             hundreds/tens/ones BCD digits
//   operand_shi/ge      operand tens/ones as ASCII
//   busy, done          sequence in progress / one-cycle completion pulse
module bcd_display_sequencer #(
    parameter logic [7:0] ASCII_ZERO  = 8'h30,
    parameter logic [7:0] ASCII_BLANK = 8'h20,
    parameter bit         AUTO_TRIG   = 1'b1
) (
    input  logic       CLK,
    input  logic       CLRn,
    input  logic       T6,
    input  logic       start,
    input  logic [7:0] acc_in,
    input  logic [7:0] b_in,
    input  logic [7:0] operand_in,
    input  logic       operand_blank,
    output logic [3:0] A_bai,
    output logic [3:0] A_shi,
    output logic [3:0] A_ge,
    output logic [3:0] B_bai,
    output logic [3:0] B_shi,
    output logic [3:0] B_ge,
    output logic [7:0] operand_shi,
    output logic [7:0] operand_ge,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_e;

    state_e              state_q, state_d;
    logic [1:0]          ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [DATA_W-1:0]   snap_acc_q, snap_acc_d;
    logic [DATA_W-1:0]   snap_b_q, snap_b_d;
    logic [DATA_W-1:0]   snap_op_q, snap_op_d;
    logic                snap_blank_q, snap_blank_d;
    logic                pending_q, pending_d;
    logic                t6_q, t6_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [11:0]         a_q, a_d;
    logic [11:0]         b_q, b_d;
    logic [7:0]          op_shi_q, op_shi_d;
    logic [7:0]          op_ge_q, op_ge_d;

    logic                trig_c;
    logic [BCD_W-1:0]    adj_c;

    // Double-dabble correction: a nibble >= 5 would overflow past 9 after the shift.
    function automatic logic [3:0] adj_nib(input logic [3:0] nib);
        return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    endfunction

    assign trig_c = start | (AUTO_TRIG & T6 & ~t6_q);
    assign adj_c  = {adj_nib(bcd_q[11:8]), adj_nib(bcd_q[7:4]), adj_nib(bcd_q[3:0])};

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        cnt_d        = cnt_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        snap_acc_d   = snap_acc_q;
        snap_b_d     = snap_b_q;
        snap_op_d    = snap_op_q;
        snap_blank_d = snap_blank_q;
        pending_d    = pending_q;
        t6_d         = T6;
        busy_d       = busy_q;
        done_d       = 1'b0;
        a_d          = a_q;
        b_d          = b_q;
        op_shi_d     = op_shi_q;
        op_ge_d      = op_ge_q;

        // Triggers during a running sequence collapse into a single pending request
        if (state_q != IDLE && trig_c) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trig_c) begin
                    snap_acc_d   = acc_in;
                    snap_b_d     = b_in;
                    snap_op_d    = operand_in;
                    snap_blank_d = operand_blank;
                    ch_d         = 2'd0;
                    busy_d       = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                case (ch_q)
                    2'd0:    bin_d = snap_acc_q;
                    2'd1:    bin_d = snap_b_q;
                    default: bin_d = snap_op_q;
                endcase
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj_c, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(7)) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                case (ch_q)
                    2'd0:    a_d = bcd_q;
                    2'd1:    b_d = bcd_q;
                    default: begin
                        op_shi_d = snap_blank_q ? ASCII_BLANK : 8'(bcd_q[7:4]) + ASCII_ZERO;
                        op_ge_d  = snap_blank_q ? ASCII_BLANK : 8'(bcd_q[3:0]) + ASCII_ZERO;
                    end
                endcase
                if (ch_q != 2'd2) begin
                    ch_d    = ch_q + 2'd1;
                    state_d = LOAD;
                end else begin
                    done_d = 1'b1;
                    // A trigger in this very cycle counts as pending too
                    if (pending_q || trig_c) begin
                        pending_d    = 1'b0;
                        snap_acc_d   = acc_in;
                        snap_b_d     = b_in;
                        snap_op_d    = operand_in;
                        snap_blank_d = operand_blank;
                        ch_d         = 2'd0;
                        state_d      = LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!CLRn) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            cnt_q        <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            snap_acc_q   <= '0;
            snap_b_q     <= '0;
            snap_op_q    <= '0;
            snap_blank_q <= 1'b0;
            pending_q    <= 1'b0;
            t6_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_shi_q     <= ASCII_BLANK;
            op_ge_q      <= ASCII_BLANK;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            snap_acc_q   <= snap_acc_d;
            snap_b_q     <= snap_b_d;
            snap_op_q    <= snap_op_d;
            snap_blank_q <= snap_blank_d;
            pending_q    <= pending_d;
            t6_q         <= t6_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_shi_q     <= op_shi_d;
            op_ge_q      <= op_ge_d;
        end
    end

    assign {A_bai, A_shi, A_ge} = a_q;
    assign {B_bai, B_shi, B_ge} = b_q;
    assign operand_shi          = op_shi_q;
    assign operand_ge           = op_ge_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Directed bench: main instance (AUTO_TRIG=1) and a start-only instance (AUTO_TRIG=0).
module tb_bcd_display_sequencer;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       t6;
    logic       start;
    logic       start_m;
    logic [7:0] acc_in, b_in, operand_in;
    logic       operand_blank;

    logic [3:0] a_bai, a_shi, a_ge, b_bai, b_shi, b_ge;
    logic [7:0] op_shi, op_ge;
    logic       busy, done;

    logic [3:0] m_a_bai, m_a_shi, m_a_ge, m_b_bai, m_b_shi, m_b_ge;
    logic [7:0] m_op_shi, m_op_ge;
    logic       m_busy, m_done;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    bcd_display_sequencer u_dut (
        .CLK(clk), .CLRn(clr_n), .T6(t6), .start(start),
        .acc_in(acc_in), .b_in(b_in), .operand_in(operand_in), .operand_blank(operand_blank),
        .A_bai(a_bai), .A_shi(a_shi), .A_ge(a_ge),
        .B_bai(b_bai), .B_shi(b_shi), .B_ge(b_ge),
        .operand_shi(op_shi), .operand_ge(op_ge), .busy(busy), .done(done)
    );

    bcd_display_sequencer #(.AUTO_TRIG(1'b0)) u_man (
        .CLK(clk), .CLRn(clr_n), .T6(t6), .start(start_m),
        .acc_in(acc_in), .b_in(b_in), .operand_in(operand_in), .operand_blank(operand_blank),
        .A_bai(m_a_bai), .A_shi(m_a_shi), .A_ge(m_a_ge),
        .B_bai(m_b_bai), .B_shi(m_b_shi), .B_ge(m_b_ge),
        .operand_shi(m_op_shi), .operand_ge(m_op_ge), .busy(m_busy), .done(m_done)
    );

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise T6 so that the next edge (edge k) sees a rising edge; returns just after edge k
    task automatic t6_rise();
        t6 = 1'b1;
        step(1);
        t6 = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; t6 = 1'b0; start = 1'b0; start_m = 1'b0;
        acc_in = '0; b_in = '0; operand_in = '0; operand_blank = 1'b0;
        step(3);
        clr_n = 1'b1;
        step(1);
        vecs++;
        if ({a_bai, a_shi, a_ge, b_bai, b_shi, b_ge} !== 24'h0) begin
            errs++; $display("FAIL reset_bcd got %h want 000000", {a_bai, a_shi, a_ge, b_bai, b_shi, b_ge});
        end
        vecs++;
        if ({op_shi, op_ge} !== 16'h2020) begin
            errs++; $display("FAIL reset_operand got %h want 2020", {op_shi, op_ge});
        end
        vecs++;
        if ({busy, done} !== 2'b00) begin
            errs++; $display("FAIL reset_flags busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        acc_in = 8'd255; b_in = 8'd0; operand_in = 8'd37; operand_blank = 1'b0;
        t6_rise();                                   // edge k
        vecs++;
        if ({busy, done} !== 2'b10) begin
            errs++; $display("FAIL basic_busy_k got %b want 10", {busy, done});
        end
        acc_in = 8'd0; b_in = 8'd99; operand_in = 8'd0; // snapshot must isolate these
        step(9);                                     // k+9
        vecs++;
        if ({a_bai, a_shi, a_ge} !== 12'h000) begin
            errs++; $display("FAIL basic_a_early got %h want 000", {a_bai, a_shi, a_ge});
        end
        step(1);                                     // k+10
        vecs++;
        if ({a_bai, a_shi, a_ge} !== 12'h255) begin
            errs++; $display("FAIL basic_a got %h want 255", {a_bai, a_shi, a_ge});
        end
        step(10);                                    // k+20
        vecs++;
        if ({b_bai, b_shi, b_ge} !== 12'h000) begin
            errs++; $display("FAIL basic_b got %h want 000", {b_bai, b_shi, b_ge});
        end
        vecs++;
        if ({op_shi, op_ge} !== 16'h2020) begin
            errs++; $display("FAIL basic_op_early got %h want 2020", {op_shi, op_ge});
        end
        step(10);                                    // k+30
        vecs++;
        if ({op_shi, op_ge} !== 16'h3337) begin
            errs++; $display("FAIL basic_op got %h want 3337", {op_shi, op_ge});
        end
        vecs++;
        if ({busy, done} !== 2'b01) begin
            errs++; $display("FAIL basic_done got %b want 01", {busy, done});
        end
        step(1);
        vecs++;
        if ({busy, done} !== 2'b00) begin
            errs++; $display("FAIL basic_done_pulse got %b want 00", {busy, done});
        end
    endtask

    task automatic test_blank();
        acc_in = 8'd100; b_in = 8'd147; operand_in = 8'd99; operand_blank = 1'b1;
        t6_rise();
        step(10);
        vecs++;
        if ({a_bai, a_shi, a_ge} !== 12'h100) begin
            errs++; $display("FAIL blank_a got %h want 100", {a_bai, a_shi, a_ge});
        end
        step(10);
        vecs++;
        if ({b_bai, b_shi, b_ge} !== 12'h147) begin
            errs++; $display("FAIL blank_b got %h want 147", {b_bai, b_shi, b_ge});
        end
        step(10);
        vecs++;
        if ({op_shi, op_ge, done} !== {16'h2020, 1'b1}) begin
            errs++; $display("FAIL blank_op got %h/%b want 2020/1", {op_shi, op_ge}, done);
        end
        operand_blank = 1'b0;
        step(2);
    endtask

    task automatic test_back_to_back();
        acc_in = 8'd12; b_in = 8'd5; operand_in = 8'd8; operand_blank = 1'b0;
        t6_rise();                                   // k
        step(3);                                     // k+3
        acc_in = 8'd200;
        step(1);                                     // k+4
        t6_rise();                                   // k+5: pending
        step(5);                                     // k+10
        vecs++;
        if ({a_bai, a_shi, a_ge} !== 12'h012) begin
            errs++; $display("FAIL b2b_a1 got %h want 012", {a_bai, a_shi, a_ge});
        end
        step(10);                                    // k+20
        vecs++;
        if ({b_bai, b_shi, b_ge} !== 12'h005) begin
            errs++; $display("FAIL b2b_b1 got %h want 005", {b_bai, b_shi, b_ge});
        end
        step(10);                                    // k+30
        vecs++;
        if ({op_shi, op_ge, busy, done} !== {16'h3038, 2'b11}) begin
            errs++; $display("FAIL b2b_end1 got %h/%b want 3038/11", {op_shi, op_ge}, {busy, done});
        end
        step(1);
        vecs++;
        if ({busy, done} !== 2'b10) begin
            errs++; $display("FAIL b2b_mid got %b want 10", {busy, done});
        end
        step(9);                                     // k+40
        vecs++;
        if ({a_bai, a_shi, a_ge} !== 12'h200) begin
            errs++; $display("FAIL b2b_a2 got %h want 200", {a_bai, a_shi, a_ge});
        end
        step(20);                                    // k+60
        vecs++;
        if ({busy, done} !== 2'b01) begin
            errs++; $display("FAIL b2b_end2 got %b want 01", {busy, done});
        end
        step(2);
    endtask

    task automatic test_mid_reset();
        int done_cnt;
        acc_in = 8'd77; b_in = 8'd88; operand_in = 8'd42;
        t6_rise();                                   // k
        step(14);                                    // k+14
        clr_n = 1'b0;
        step(1);                                     // k+15
        clr_n = 1'b1;
        vecs++;
        if ({a_bai, a_shi, a_ge, b_bai, b_shi, b_ge, op_shi, op_ge, busy, done} !== {24'h0, 16'h2020, 2'b00}) begin
            errs++; $display("FAIL midrst_state got %h %h %b want 000000 2020 00",
                             {a_bai, a_shi, a_ge, b_bai, b_shi, b_ge}, {op_shi, op_ge}, {busy, done});
        end
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        vecs++;
        if (done_cnt !== 0) begin
            errs++; $display("FAIL midrst_quiet active cycles got %0d want 0", done_cnt);
        end
        t6_rise();
        step(30);
        vecs++;
        if ({a_bai, a_shi, a_ge, b_bai, b_shi, b_ge, op_shi, op_ge, done} !== {24'h077088, 16'h3432, 1'b1}) begin
            errs++; $display("FAIL midrst_reconvert got %h %h %b want 077088 3432 1",
                             {a_bai, a_shi, a_ge, b_bai, b_shi, b_ge}, {op_shi, op_ge}, done);
        end
        step(2);
    endtask

    task automatic test_manual();
        int act;
        acc_in = 8'd19; b_in = 8'd250; operand_in = 8'd60; operand_blank = 1'b0;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            t6 = ~t6;
            step(1);
            if (m_busy === 1'b1 || m_done === 1'b1) act++;
        end
        t6 = 1'b0;
        vecs++;
        if (act !== 0 || {m_a_bai, m_a_shi, m_a_ge} !== 12'h000) begin
            errs++; $display("FAIL manual_t6_ignored act %0d A %h want 0 000", act, {m_a_bai, m_a_shi, m_a_ge});
        end
        start_m = 1'b1;
        step(1);                                     // k
        start_m = 1'b0;
        vecs++;
        if (m_busy !== 1'b1) begin
            errs++; $display("FAIL manual_busy got %b want 1", m_busy);
        end
        step(10);
        vecs++;
        if ({m_a_bai, m_a_shi, m_a_ge} !== 12'h019) begin
            errs++; $display("FAIL manual_a got %h want 019", {m_a_bai, m_a_shi, m_a_ge});
        end
        step(10);
        vecs++;
        if ({m_b_bai, m_b_shi, m_b_ge} !== 12'h250) begin
            errs++; $display("FAIL manual_b got %h want 250", {m_b_bai, m_b_shi, m_b_ge});
        end
        step(10);
        vecs++;
        if ({m_op_shi, m_op_ge, m_busy, m_done} !== {16'h3630, 2'b01}) begin
            errs++; $display("FAIL manual_end got %h/%b want 3630/01", {m_op_shi, m_op_ge}, {m_busy, m_done});
        end
        step(1);
        vecs++;
        if (m_done !== 1'b0) begin
            errs++; $display("FAIL manual_done_pulse got %b want 0", m_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_back_to_back();
        test_mid_reset();
        test_manual();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
